wb_mem_arbiter: RTL and testbench
=================================

Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter. It shares a single physical memory port between the pipeline's instruction-fetch master and its data-memory master.
- Sits between the pipelined LC-3b datapath and the unified line-based memory or cache. Lines are 128 bits, and addresses are 12-bit line addresses.
- Grants one master at a time, holds the grant until the slave acknowledges, and enforces a slave-response timeout.

Parameters:
- TIMEOUT, 64: maximum cycles a granted transaction may wait for pmem_ack before it is errored. 0 disables the timeout.
- ADR_W, 12: line-address width.
- DAT_W, 128: line data width. SEL width is DAT_W/8.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifetch_cyc / ifetch_stb / ifetch_we  in  1 each  fetch-master cycle, strobe and write-enable.
- ifetch_sel  in  16  fetch byte selects.
- ifetch_adr  in  12  fetch line address.
- ifetch_dat_m  in  128  fetch write data.
- ifetch_dat_s  out  128  read data returned to the fetch master.
- ifetch_ack / ifetch_err  out  1 each  fetch-master completion / error.
- dmem_cyc, dmem_stb, dmem_we, dmem_sel, dmem_adr, dmem_dat_m, dmem_dat_s, dmem_ack, dmem_err: same directions and widths as the ifetch_* group, for the data master.
- pmem_cyc / pmem_stb / pmem_we  out  1 each  slave-side cycle, strobe and write-enable.
- pmem_sel  out  16  slave-side byte selects.
- pmem_adr  out  12  slave-side line address.
- pmem_dat_m  out  128  slave-side write data.
- pmem_dat_s  in  128  read data from the slave.
- pmem_ack  in  1  slave acknowledge.

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset rst is asynchronous and active-high.
  - On reset: state=IDLE, wait counter=0, last_grant=IFETCH.
  - On reset all pmem_* outputs, *_ack and *_err are 0. ifetch_dat_s and dmem_dat_s follow pmem_dat_s.
- State machine, three states:
  - IDLE:
    - A master requests when its cyc & stb = 1.
    - If only one master requests, go to that master's grant state.
    - If both request, DMEM wins (fixed priority; see Optional Feature).
    - With no request, remain in IDLE.
    - In IDLE, pmem_cyc=pmem_stb=0.
  - G_IFETCH / G_DMEM:
    - pmem_cyc, stb, we, sel, adr and dat_m are combinationally muxed from the granted master.
    - The granted master's ack = pmem_ack. Its err is defined under the timeout rules below.
    - The non-granted master's ack and err are always 0.
    - Exit to IDLE on: pmem_ack=1; the granted master's err pulse; or the granted master dropping cyc (abort, nothing forwarded).
    - On exit, last_grant is updated to the granted master.
- Latency and handshake:
  - A request first seen in IDLE at cycle N is driven to pmem at N+1.
  - A completed transaction costs at least 2 cycles plus slave latency, because one IDLE cycle separates grants.
  - Masters must hold all request signals stable until ack or err (Wishbone classic).
  - pmem_dat_s is broadcast to both *_dat_s at all times. Masters qualify it with ack.
- Timeout:
  - The counter clears on entry to a grant state and increments each granted cycle without pmem_ack. It saturates at TIMEOUT.
  - When the counter equals TIMEOUT-1 and pmem_ack=0, the granted master's err=1 for that single cycle. pmem_cyc and pmem_stb are forced to 0 the following cycle (IDLE).
  - A pmem_ack arriving in the same cycle as the would-be error wins: ack=1, err=0.
  - TIMEOUT=0: err is never asserted and the counter stays at 0.
- Mid-operation reset: all outputs drop immediately (asynchronously). The in-flight transaction is discarded and no ack is forwarded.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the master that is not last_grant. Reset value last_grant=IFETCH, so DMEM wins the first tie.
- Undefined: fixed DMEM priority, and last_grant is unused. Synthesis trims it.

Test Plan:
- Single fetch request: ifetch_cyc=stb=1, adr=12'h010, slave acks 2 cycles after pmem_stb -> pmem_adr=12'h010 from cycle N+1; ifetch_ack=1 for exactly one cycle; ifetch_dat_s equals slave data; dmem_ack stays 0.
- Simultaneous requests, macro undefined: both request continuously -> grant order DMEM, DMEM, DMEM; ifetch is never acked while dmem_cyc stays high.
- Simultaneous requests, WB_ARB_ROUND_ROBIN_EN defined -> grant order DMEM, IFETCH, DMEM, IFETCH, each separated by one IDLE cycle.
- Timeout: TIMEOUT=4, dmem store (we=1, sel=16'h0030) and the slave never acks -> dmem_err=1 in the 4th granted cycle; pmem_stb=0 the next cycle; a following ifetch request is then granted normally.
- Ack/timeout collision: TIMEOUT=4, pmem_ack in the 4th granted cycle -> ack=1, err=0.
- Abort and reset: dmem drops cyc mid-grant -> IDLE next cycle with no ack. Assert rst mid-grant -> pmem_cyc=0 immediately; after release, state is IDLE and the next tie goes to DMEM.

Source files
------------

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone classic bus bundle for one line-based port (cyc/stb/we/sel/adr/data/ack/err).
// The physical memory side has no error line, so err is omitted from the master modport.
interface wb_mem_arbiter_if #(
  parameter int ADR_W = 12,
  parameter int DAT_W = 128
);
  logic               cyc;
  logic               stb;
  logic               we;
  logic [DAT_W/8-1:0] sel;
  logic [ADR_W-1:0]   adr;
  logic [DAT_W-1:0]   dat_m;
  logic [DAT_W-1:0]   dat_s;
  logic               ack;
  logic               err;

  modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack, err);
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master (ifetch, dmem) to one-slave Wishbone arbiter with slave-response timeout.
// Optional macro WB_ARB_ROUND_ROBIN_EN: ties alternate instead of fixed DMEM priority.
module wb_mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int ADR_W   = 12,
  parameter int DAT_W   = 128
) (
  input  logic              clk,
  input  logic              rst,
  wb_mem_arbiter_if.slave   ifetch,
  wb_mem_arbiter_if.slave   dmem,
  wb_mem_arbiter_if.master  pmem
);
  localparam int SEL_W = DAT_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, G_IFETCH, G_DMEM} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             ifetch_req;
  logic             dmem_req;
  logic             timeout_hit;

  assign ifetch_req = ifetch.cyc & ifetch.stb;
  assign dmem_req   = dmem.cyc & dmem.stb;

  // Read data is broadcast; masters qualify it with their own ack.
  assign ifetch.dat_s = pmem.dat_s;
  assign dmem.dat_s   = pmem.dat_s;

  // An ack in the final allowed cycle beats the error.
  assign timeout_hit = (TIMEOUT != 0) && (state_reg != IDLE) &&
                       (cnt_reg == CNT_LAST) && !pmem.ack;

`ifdef WB_ARB_ROUND_ROBIN_EN
  typedef enum logic {GRANT_IFETCH, GRANT_DMEM} grant_t;
  grant_t last_grant_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= GRANT_IFETCH;
    end else if (state_reg != IDLE && state_next == IDLE) begin
      last_grant_reg <= (state_reg == G_DMEM) ? GRANT_DMEM : GRANT_IFETCH;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // IDLE always separates grants, so clearing here clears on grant entry.
      if (state_reg == IDLE) begin
        cnt_reg <= '0;
      end else if (!pmem.ack && cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    pmem.cyc    = 1'b0;
    pmem.stb    = 1'b0;
    pmem.we     = 1'b0;
    pmem.sel    = {SEL_W{1'b0}};
    pmem.adr    = {ADR_W{1'b0}};
    pmem.dat_m  = {DAT_W{1'b0}};
    ifetch.ack  = 1'b0;
    ifetch.err  = 1'b0;
    dmem.ack    = 1'b0;
    dmem.err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ifetch_req && dmem_req) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          state_next = (last_grant_reg == GRANT_DMEM) ? G_IFETCH : G_DMEM;
`else
          state_next = G_DMEM;
`endif
        end else if (dmem_req) begin
          state_next = G_DMEM;
        end else if (ifetch_req) begin
          state_next = G_IFETCH;
        end
      end
      G_IFETCH: begin
        pmem.cyc   = ifetch.cyc;
        pmem.stb   = ifetch.stb;
        pmem.we    = ifetch.we;
        pmem.sel   = ifetch.sel;
        pmem.adr   = ifetch.adr;
        pmem.dat_m = ifetch.dat_m;
        ifetch.ack = pmem.ack;
        ifetch.err = timeout_hit;
        if (pmem.ack || timeout_hit || !ifetch.cyc) begin
          state_next = IDLE;
        end
      end
      G_DMEM: begin
        pmem.cyc   = dmem.cyc;
        pmem.stb   = dmem.stb;
        pmem.we    = dmem.we;
        pmem.sel   = dmem.sel;
        pmem.adr   = dmem.adr;
        pmem.dat_m = dmem.dat_m;
        dmem.ack   = pmem.ack;
        dmem.err   = timeout_hit;
        if (pmem.ack || timeout_hit || !dmem.cyc) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: scoreboard of expected completions checked by a
// negedge monitor, plus cycle-exact checks of the slave-side mux in the main sequence.
module tb_wb_mem_arbiter;
  localparam int ADR_W   = 12;
  localparam int DAT_W   = 128;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) ifetch_bus ();
  wb_mem_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dmem_bus ();
  wb_mem_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) pmem_bus ();

  wb_mem_arbiter #(.TIMEOUT(TIMEOUT), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .ifetch (ifetch_bus),
    .dmem   (dmem_bus),
    .pmem   (pmem_bus)
  );

  typedef struct {
    logic         who;   // 0 = ifetch, 1 = dmem
    logic         ack;
    logic         err;
    logic [127:0] dat;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] slv_rdata = '0;
  int           slv_delay = 1;
  bit           slv_never = 1'b0;

  assign pmem_bus.dat_s = slv_rdata;
  assign pmem_bus.err   = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_exp(input logic who, input logic ack, input logic err, input logic [127:0] dat);
    exp_t e;
    e.who = who; e.ack = ack; e.err = err; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic drive_ifetch(input logic req, input logic we, input logic [15:0] sel,
                              input logic [11:0] adr, input logic [127:0] dat);
    ifetch_bus.cyc = req; ifetch_bus.stb = req; ifetch_bus.we = we;
    ifetch_bus.sel = sel; ifetch_bus.adr = adr; ifetch_bus.dat_m = dat;
  endtask

  task automatic drive_dmem(input logic req, input logic we, input logic [15:0] sel,
                            input logic [11:0] adr, input logic [127:0] dat);
    dmem_bus.cyc = req; dmem_bus.stb = req; dmem_bus.we = we;
    dmem_bus.sel = sel; dmem_bus.adr = adr; dmem_bus.dat_m = dat;
  endtask

  task automatic wait_done(input string tag, output int ncyc);
    logic done;
    done = 1'b0;
    ncyc = 0;
    while (!done && ncyc < 20) begin
      @(negedge clk);
      ncyc++;
      done = ifetch_bus.ack | ifetch_bus.err | dmem_bus.ack | dmem_bus.err;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  // Slave model: acks slv_delay cycles after the request first appears.
  initial begin : slave
    int   cnt;
    logic busy;
    cnt = 0;
    pmem_bus.ack = 1'b0;
    forever begin
      @(negedge clk);
      busy = pmem_bus.cyc && pmem_bus.stb && !rst;
      @(posedge clk);
      #1;
      if (busy && !pmem_bus.ack) begin
        cnt++;
        if (!slv_never && cnt == slv_delay) pmem_bus.ack = 1'b1;
      end else begin
        pmem_bus.ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Completion monitor: every ack/err seen by a master is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    logic i_any;
    logic d_any;
    exp_t e;
    i_any = ifetch_bus.ack | ifetch_bus.err;
    d_any = dmem_bus.ack | dmem_bus.err;
    if (!rst && (i_any || d_any)) begin
      check("exclusive", i_any & d_any, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", {d_any, i_any}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("who", d_any, e.who);
        check("ack", d_any ? dmem_bus.ack : ifetch_bus.ack, e.ack);
        check("err", d_any ? dmem_bus.err : ifetch_bus.err, e.err);
        check("dat_s", d_any ? dmem_bus.dat_s : ifetch_bus.dat_s, e.dat);
        $display("txn t=%0t master=%s ack=%0b err=%0b adr=%03h dat=%032h", $time,
                 d_any ? "dmem" : "ifetch", d_any ? dmem_bus.ack : ifetch_bus.ack,
                 d_any ? dmem_bus.err : ifetch_bus.err, pmem_bus.adr,
                 d_any ? dmem_bus.dat_s : ifetch_bus.dat_s);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int           n;
    logic [127:0] d;
    logic [127:0] dm;
    logic         who_seq[4];

    drive_ifetch(1'b0, 1'b0, 16'h0, 12'h0, '0);
    drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
    slv_rdata = rnd128();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pmem_cyc", pmem_bus.cyc, 1'b0);
    check("rst_pmem_stb", pmem_bus.stb, 1'b0);
    check("rst_ifetch_ack", ifetch_bus.ack, 1'b0);
    check("rst_dmem_err", dmem_bus.err, 1'b0);
    check("rst_ifetch_dat_s", ifetch_bus.dat_s, slv_rdata);
    check("rst_dmem_dat_s", dmem_bus.dat_s, slv_rdata);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch, slave acks 2 cycles after strobe
    @(posedge clk); #1;
    slv_delay = 2;
    d = rnd128();
    slv_rdata = d;
    push_exp(1'b0, 1'b1, 1'b0, d);
    drive_ifetch(1'b1, 1'b0, 16'hFFFF, 12'h010, rnd128());
    @(negedge clk);
    check("t1_idle_cycle", pmem_bus.cyc, 1'b0);
    @(negedge clk);
    check("t1_pmem_cyc", pmem_bus.cyc, 1'b1);
    check("t1_pmem_adr", pmem_bus.adr, 12'h010);
    check("t1_pmem_we", pmem_bus.we, 1'b0);
    wait_done("t1", n);
    check("t1_latency", n, 2);
    @(posedge clk); #1;
    drive_ifetch(1'b0, 1'b0, 16'h0, 12'h0, '0);
    @(negedge clk);
    check("t1_ack_one_cycle", ifetch_bus.ack, 1'b0);
    check("t1_pmem_idle", pmem_bus.cyc, 1'b0);

    // Simultaneous continuous requests
`ifdef WB_ARB_ROUND_ROBIN_EN
    who_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    who_seq = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    @(posedge clk); #1;
    slv_delay = 1;
    drive_ifetch(1'b1, 1'b0, 16'hFFFF, 12'h020, rnd128());
    drive_dmem(1'b1, 1'b0, 16'hFFFF, 12'h030, rnd128());
    for (int i = 0; i < 4; i++) begin
      d = rnd128();
      slv_rdata = d;
      push_exp(who_seq[i], 1'b1, 1'b0, d);
      wait_done("t2", n);
      check("t2_grant_adr", pmem_bus.adr, who_seq[i] ? 12'h030 : 12'h020);
      @(posedge clk); #1;
      if (i == 2) drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
      if (i == 3) begin
        drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
        drive_ifetch(1'b0, 1'b0, 16'h0, 12'h0, '0);
      end
      @(negedge clk);
      check("t2_idle_gap", pmem_bus.cyc, 1'b0);
    end

    // Timeout on a dmem store that is never acked
    @(posedge clk); #1;
    slv_never = 1'b1;
    d = rnd128();
    slv_rdata = d;
    push_exp(1'b1, 1'b0, 1'b1, d);
    dm = rnd128();
    drive_dmem(1'b1, 1'b1, 16'h0030, 12'h123, dm);
    @(negedge clk);
    check("t3_idle_cycle", pmem_bus.cyc, 1'b0);
    @(negedge clk);
    check("t3_pmem_we", pmem_bus.we, 1'b1);
    check("t3_pmem_sel", pmem_bus.sel, 16'h0030);
    check("t3_pmem_dat_m", pmem_bus.dat_m, dm);
    check("t3_no_early_err", dmem_bus.err, 1'b0);
    wait_done("t3", n);
    check("t3_err_cycle", n, 3);
    @(posedge clk); #1;
    drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
    slv_never = 1'b0;
    slv_delay = 1;
    d = rnd128();
    slv_rdata = d;
    push_exp(1'b0, 1'b1, 1'b0, d);
    drive_ifetch(1'b1, 1'b0, 16'hFFFF, 12'h040, rnd128());
    @(negedge clk);
    check("t3_stb_dropped", pmem_bus.stb, 1'b0);
    check("t3_err_single", dmem_bus.err, 1'b0);
    wait_done("t3_fetch", n);
    check("t3_fetch_adr", pmem_bus.adr, 12'h040);
    @(posedge clk); #1;
    drive_ifetch(1'b0, 1'b0, 16'h0, 12'h0, '0);

    // Ack in the same cycle as the would-be timeout
    @(posedge clk); #1;
    slv_delay = 3;
    d = rnd128();
    slv_rdata = d;
    push_exp(1'b1, 1'b1, 1'b0, d);
    drive_dmem(1'b1, 1'b0, 16'hFFFF, 12'h200, rnd128());
    @(negedge clk);
    @(negedge clk);
    check("t4_granted", pmem_bus.cyc, 1'b1);
    wait_done("t4", n);
    check("t4_ack_cycle", n, 3);
    check("t4_err_low", dmem_bus.err, 1'b0);
    @(posedge clk); #1;
    drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
    @(negedge clk);
    check("t4_back_idle", pmem_bus.cyc, 1'b0);

    // Abort: dmem drops cyc mid-grant
    @(posedge clk); #1;
    slv_never = 1'b1;
    drive_dmem(1'b1, 1'b0, 16'hFFFF, 12'h300, rnd128());
    @(negedge clk);
    @(negedge clk);
    check("t5_granted", pmem_bus.cyc, 1'b1);
    @(posedge clk); #1;
    drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
    @(negedge clk);
    check("t5_cyc_dropped", pmem_bus.cyc, 1'b0);
    check("t5_no_ack", dmem_bus.ack, 1'b0);
    @(posedge clk); #1;
    slv_never = 1'b0;
    slv_delay = 1;
    d = rnd128();
    slv_rdata = d;
    push_exp(1'b0, 1'b1, 1'b0, d);
    drive_ifetch(1'b1, 1'b0, 16'hFFFF, 12'h050, rnd128());
    @(negedge clk);
    check("t5_idle_cycle", pmem_bus.cyc, 1'b0);
    @(negedge clk);
    check("t5_next_grant", pmem_bus.cyc, 1'b1);
    check("t5_next_adr", pmem_bus.adr, 12'h050);
    wait_done("t5", n);
    @(posedge clk); #1;
    drive_ifetch(1'b0, 1'b0, 16'h0, 12'h0, '0);

    // Asynchronous reset mid-grant, then a tie
    @(posedge clk); #1;
    slv_never = 1'b1;
    drive_dmem(1'b1, 1'b0, 16'hFFFF, 12'h310, rnd128());
    @(negedge clk);
    @(negedge clk);
    check("t6_granted", pmem_bus.cyc, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_cyc", pmem_bus.cyc, 1'b0);
    check("t6_async_stb", pmem_bus.stb, 1'b0);
    check("t6_no_ack", dmem_bus.ack, 1'b0);
    drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    slv_never = 1'b0;
    slv_delay = 1;
    d = rnd128();
    slv_rdata = d;
    push_exp(1'b1, 1'b1, 1'b0, d);
    drive_ifetch(1'b1, 1'b0, 16'hFFFF, 12'h060, rnd128());
    drive_dmem(1'b1, 1'b0, 16'hFFFF, 12'h070, rnd128());
    @(negedge clk);
    check("t6_idle_cycle", pmem_bus.cyc, 1'b0);
    @(negedge clk);
    check("t6_tie_dmem", pmem_bus.adr, 12'h070);
    wait_done("t6", n);
    @(posedge clk); #1;
    drive_ifetch(1'b0, 1'b0, 16'h0, 12'h0, '0);
    drive_dmem(1'b0, 1'b0, 16'h0, 12'h0, '0);
    repeat (2) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
